// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter family (up counter and down-counter timer).
package counter_pkg;
   localparam int   CNT_WIDTH    = 4;
   localparam logic ST_IDLE      = 1'b0;
   localparam logic ST_RUN       = 1'b1;
   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_RELOAD  = 1'b1;

   typedef enum logic {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN
   } state_e;
endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with terminal-count pulse, one-shot or auto-reload.
module down_counter_timer
   import counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             mode,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy
);

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rel_q, rel_d;
   logic             tc_q, tc_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= ZERO;
         rel_q   <= ZERO;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rel_q   <= rel_d;
         tc_q    <= tc_d;
      end
   end

   // tc defaults low so it can only ever be a single-cycle pulse.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rel_d   = rel_q;
      tc_d    = 1'b0;
      if (clear) begin
         state_d = S_IDLE;
         cnt_d   = ZERO;
      end else if (load) begin
         rel_d   = load_val;
         cnt_d   = load_val;
         state_d = (load_val != ZERO) ? S_RUN : S_IDLE;
      end else if (state_q == S_RUN && en) begin
         if (cnt_q > ONE) begin
            cnt_d = cnt_q - ONE;
         end else if (cnt_q == ONE) begin
            // mode only matters here: it decides whether the count keeps running.
            cnt_d   = ZERO;
            tc_d    = 1'b1;
            state_d = (mode == MODE_RELOAD) ? S_RUN : S_IDLE;
         end else begin
            cnt_d = rel_q;
         end
      end
   end

   assign q    = cnt_q;
   assign tc   = tc_q;
   assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed and randomized checks of down_counter_timer against a behavioural model.
`timescale 1ns/1ps
module tb_down_counter_timer;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset, clear, load, en, mode;
   logic [W-1:0] load_val;
   logic [W-1:0] q;
   logic         tc, busy;

   int n_cmp  = 0;
   int n_fail = 0;

   // Behavioural model: remaining count, period register, running flag, pulse.
   int mq, mrel, mtc;
   bit mrun;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .clear(clear), .load(load),
      .load_val(load_val), .en(en), .mode(mode),
      .q(q), .tc(tc), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".q"},    32'(q),    32'(mq));
      chk({tag, ".tc"},   32'(tc),   32'(mtc));
      chk({tag, ".busy"}, 32'(busy), 32'(mrun));
   endtask

   task automatic model_reset();
      mq = 0; mrel = 0; mtc = 0; mrun = 1'b0;
   endtask

   // Applies the per-edge rules in priority order: clear, load, count, hold.
   task automatic model_edge();
      int v;
      v   = int'(load_val);
      mtc = 0;
      if (!reset) begin
         model_reset();
      end else if (clear) begin
         mq = 0; mrun = 1'b0;
      end else if (load) begin
         mrel = v; mq = v; mrun = (v != 0);
      end else if (mrun && en) begin
         if (mq == 0) begin
            mq = mrel;
         end else begin
            mq = mq - 1;
            if (mq == 0) begin
               mtc  = 1;
               mrun = mode;
            end
         end
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle_inputs();
      clear = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0; load_val = '0;
   endtask

   initial begin
      int ncyc;
      idle_inputs();
      reset = 1'b0;
      model_reset();
      #1;
      check_all("rst_async");

      // Reset held while load is strobed.
      load = 1'b1; load_val = 4'd9;
      for (int i = 0; i < 3; i++) step("rst_hold");
      reset = 1'b1; load = 1'b0;
      step("rst_release");
      chk("rst_release_q", 32'(q), 32'd0);

      // One-shot from 3.
      mode = 1'b0; en = 1'b1; load = 1'b1; load_val = 4'd3;
      step("os_load");
      load = 1'b0;
      step("os_2");
      step("os_1");
      step("os_0");
      chk("os_tc_at_0", 32'({q, tc, busy}), 32'({4'd0, 1'b1, 1'b0}));
      step("os_after");
      step("os_after2");

      // Auto-reload from 2, then gate en at q=1.
      mode = 1'b1; load = 1'b1; load_val = 4'd2;
      step("ar_load");
      load = 1'b0;
      for (int i = 0; i < 7; i++) step("ar_run");
      chk("ar_q_before_gap", 32'(q), 32'd1);
      en = 1'b0;
      step("ar_gap");
      step("ar_gap");
      chk("ar_gap_hold", 32'({q, tc}), 32'({4'd1, 1'b0}));
      en = 1'b1;
      step("ar_resume");
      step("ar_reload");

      // Priority: clear beats load at q=5 in RUN.
      mode = 1'b0; load = 1'b1; load_val = 4'd8;
      step("pr_load8");
      load = 1'b0;
      for (int i = 0; i < 3; i++) step("pr_count");
      chk("pr_q5", 32'(q), 32'd5);
      clear = 1'b1; load = 1'b1; load_val = 4'd7;
      step("pr_clear_load");
      chk("pr_clear_wins", 32'({q, busy}), 32'({4'd0, 1'b0}));
      clear = 1'b0;
      step("pr_load7");
      chk("pr_load7_run", 32'({q, busy}), 32'({4'd7, 1'b1}));

      // Load of zero.
      load_val = 4'd0;
      step("lz_load0");
      load = 1'b0;
      step("lz_after");

      // Full scale one-shot with random enable gaps.
      mode = 1'b0; load = 1'b1; load_val = 4'd15;
      step("fs_load15");
      load = 1'b0;
      ncyc = 0;
      for (int i = 0; i < 100 && !tc; i++) begin
         en = ($urandom_range(3) != 0);
         if (en) ncyc++;
         step("fs_count");
      end
      chk("fs_enabled_cycles", 32'(ncyc), 32'd15);
      en = 1'b1;
      step("fs_no_wrap");

      // Asynchronous reset between edges at q=4.
      load = 1'b1; load_val = 4'd6;
      step("mr_load6");
      load = 1'b0;
      step("mr_5");
      step("mr_4");
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("mr_async");
      step("mr_hold");
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step("mr_stays_idle");

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         clear    = ($urandom_range(15) == 0);
         load     = ($urandom_range(5) == 0);
         load_val = W'($urandom_range(15));
         en       = ($urandom_range(3) != 0);
         mode     = $urandom_range(1) != 0;
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
